// File: rtl/rc5_key_expand.sv
// RC5 key schedule: loads a B-byte key into L[], seeds S[] from PW/QW, then runs the 3*max(T,C) mixing pass.
// Optional macro RC5_KEY_ZEROIZE_EN adds a ZERO state that wipes L[] and the key register before DONE.
module rc5_key_expand #(
  parameter int W = 16,
  parameter int B = 16,
  parameter int R = 12,
  parameter int U = W / 8,
  parameter int C = B / U,
  parameter int T = 2 * (R + 1),
  parameter logic [W-1:0] PW = 16'hb7e1,
  parameter logic [W-1:0] QW = 16'h9e37
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 key_we,
  input  logic [$clog2(B)-1:0] key_addr,
  input  logic [7:0]           key_byte,
  input  logic [$clog2(T)-1:0] s_addr,
  output logic [W-1:0]         s_data,
  output logic                 busy,
  output logic                 done
);

  localparam int KAW  = $clog2(B);
  localparam int SAW  = $clog2(T);
  localparam int LW   = (C > 1) ? $clog2(C) : 1;
  localparam int N    = 3 * ((T > C) ? T : C);
  localparam int CNTW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    LOADL,
    INITS,
    MIX,
`ifdef RC5_KEY_ZEROIZE_EN
    ZERO,
`endif
    DONE
  } state_t;

  state_t state, state_next;

  logic [KAW-1:0]  k;
  logic [SAW-1:0]  i;
  logic [LW-1:0]   j;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    a_reg, b_reg;

  logic [7:0]   key_mem [B];
  logic [W-1:0] l_mem   [C];
  logic [W-1:0] s_mem   [T];

  logic           busy_int, key_ok, key_in_range, s_in_range;
  logic           load_last, i_last, j_last, mix_last;
  logic [LW-1:0]  l_load_idx;
  logic [SAW-1:0] i_prev;
  logic [W-1:0]   s_init_val, l_load_val, a_new, b_new;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [W-1:0] amt);
    logic [2*W-1:0] d;
    d = {x, x} << (amt % W);
    return d[2*W-1:W];
  endfunction

  // Address ranges that exactly fill their index width need no compare
  if ((1 << KAW) == B) begin : g_key_full
    assign key_in_range = 1'b1;
  end else begin : g_key_part
    assign key_in_range = (key_addr < KAW'(B));
  end

  if ((1 << SAW) == T) begin : g_s_full
    assign s_in_range = 1'b1;
  end else begin : g_s_part
    assign s_in_range = (s_addr < SAW'(T));
  end

  assign busy_int  = (state != IDLE) && (state != DONE);
  assign busy      = busy_int;
  assign key_ok    = key_we && !busy_int && key_in_range;
  assign load_last = (k == '0);
  assign i_last    = (i == SAW'(T - 1));
  assign j_last    = (j == LW'(C - 1));
  assign mix_last  = (cnt == CNTW'(N - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start)     state_next = LOADL;
      LOADL:      if (load_last) state_next = INITS;
      INITS:      if (i_last)    state_next = MIX;
`ifdef RC5_KEY_ZEROIZE_EN
      MIX:        if (mix_last)  state_next = ZERO;
      ZERO:       if (j_last)    state_next = DONE;
`else
      MIX:        if (mix_last)  state_next = DONE;
`endif
      default:                   state_next = IDLE;
    endcase
  end

  // One mixing iteration: A feeds straight into the B update in the same cycle
  always_comb begin
    i_prev     = (i == '0) ? '0 : i - SAW'(1);
    s_init_val = (i == '0) ? PW : s_mem[i_prev] + QW;
    l_load_idx = LW'(k / U);
    l_load_val = (l_mem[l_load_idx] << 8) + W'(key_mem[k]);
    a_new      = rotl(s_mem[i] + a_reg + b_reg, W'(3));
    b_new      = rotl(l_mem[j] + a_new + b_reg, a_new + b_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // done lags DONE entry by one cycle and clears together with a restart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      i      <= '0;
      j      <= '0;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      done   <= 1'b0;
      s_data <= '0;
    end else begin
      done   <= (state == DONE) && !start;
      s_data <= ((state_next == DONE) && s_in_range) ? s_mem[s_addr] : '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            k     <= KAW'(B - 1);
            i     <= '0;
            j     <= '0;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
          end
        end
        LOADL: k <= k - KAW'(1);
        INITS: i <= i_last ? '0 : i + SAW'(1);
        MIX: begin
          a_reg <= a_new;
          b_reg <= b_new;
          i     <= i_last ? '0 : i + SAW'(1);
          j     <= (j_last || mix_last) ? '0 : j + LW'(1);
          cnt   <= cnt + CNTW'(1);
        end
`ifdef RC5_KEY_ZEROIZE_EN
        ZERO: j <= j + LW'(1);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < B; n++) key_mem[n] <= '0;
    end else begin
      if (key_ok) key_mem[key_addr] <= key_byte;
`ifdef RC5_KEY_ZEROIZE_EN
      if ((state == ZERO) && j_last)
        for (int n = 0; n < B; n++) key_mem[n] <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < C; n++) l_mem[n] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start)
            for (int n = 0; n < C; n++) l_mem[n] <= '0;
        end
        LOADL: l_mem[l_load_idx] <= l_load_val;
        MIX:   l_mem[j] <= b_new;
`ifdef RC5_KEY_ZEROIZE_EN
        ZERO:  l_mem[j] <= '0;
`endif
        default: ;
      endcase
    end
  end

  // S[] is deliberately left unreset; only a completed run makes it valid
  always_ff @(posedge clk) begin
    case (state)
      INITS:   s_mem[i] <= s_init_val;
      MIX:     s_mem[i] <= a_new;
      default: ;
    endcase
  end

endmodule
